// File: rtl/output_argmax.sv
// Argmax over NUM_INPUTS signed neuron outputs: captures the vector on i_valid,
// scans one element per cycle, and reports the index of the first maximum.
module output_argmax #(
  parameter int NUM_INPUTS = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                             s_axi_aclk,
  input  logic                             s_axi_aresetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  input  logic                             i_intr_clear,
  output logic                             o_busy,
  output logic [31:0]                      o_data,
  output logic                             o_data_valid,
  output logic                             intr
);

  localparam int CNT_W = $clog2(NUM_INPUTS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                        state_q;
  logic signed [DATA_WIDTH-1:0]  elem_q [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  in_elem [NUM_INPUTS];
  logic signed [DATA_WIDTH-1:0]  max_q, max_d, cur_elem;
  logic [CNT_W-1:0]              cnt_q, idx_q, idx_d;
  logic                          busy_q, valid_q, intr_q;
  logic [31:0]                   data_q;
  logic                          done;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_unpack
    assign in_elem[gi] = i_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    cur_elem = elem_q[cnt_q];
    max_d    = max_q;
    idx_d    = idx_q;
    if (cur_elem > max_q) begin
      max_d = cur_elem;
      idx_d = cnt_q;
    end
    done = (state_q == SCAN) && (cnt_q == LAST);
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_INPUTS; k++) elem_q[k] <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      intr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Completion wins over a simultaneous clear.
      intr_q  <= done | (intr_q & ~i_intr_clear);
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            for (int k = 0; k < NUM_INPUTS; k++) elem_q[k] <= in_elem[k];
            max_q   <= in_elem[0];
            idx_q   <= '0;
            cnt_q   <= CNT_W'(1);
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          max_q <= max_d;
          idx_q <= idx_d;
          if (done) begin
            cnt_q   <= '0;
            data_q  <= 32'(idx_d);
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign intr         = intr_q;

endmodule

// File: tb/tb_output_argmax.sv
// Randomized and directed checks of output_argmax against a simple first-max argmax model.
module tb_output_argmax;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int VW = N * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [VW-1:0] i_data;
  logic          i_valid;
  logic          i_intr_clear;
  logic          o_busy;
  logic [31:0]   o_data;
  logic          o_data_valid;
  logic          intr;

  int n_checks = 0;
  int n_errors = 0;

  output_argmax #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .i_data        (i_data),
    .i_valid       (i_valid),
    .i_intr_clear  (i_intr_clear),
    .o_busy        (o_busy),
    .o_data        (o_data),
    .o_data_valid  (o_data_valid),
    .intr          (intr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] pack(input int a[N]);
    logic [VW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(a[k]);
    return v;
  endfunction

  // Reference: first index holding the largest signed value.
  function automatic int ref_argmax(input logic [VW-1:0] v);
    int best = 0;
    int best_val = int'($signed(v[0 +: DW]));
    for (int k = 1; k < N; k++) begin
      if (int'($signed(v[k*DW +: DW])) > best_val) begin
        best_val = int'($signed(v[k*DW +: DW]));
        best = k;
      end
    end
    return best;
  endfunction

  // Called at a negedge; pulses i_valid for edge 0, optionally a stray pulse
  // at edge late_at, and returns at the negedge where o_data_valid is seen.
  task automatic run_scan(input string tag, input logic [VW-1:0] vec,
                          input int late_at, input logic [VW-1:0] late_vec);
    int lat = -1;
    int exp_idx = ref_argmax(vec);
    i_data  = vec;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    check({tag, "_busy"}, o_busy, 1);
    for (int k = 1; k <= 40; k++) begin
      if (k == late_at) begin
        i_data  = late_vec;
        i_valid = 1'b1;
      end
      @(negedge clk);
      i_valid = 1'b0;
      if (o_data_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, N - 1);
    check({tag, "_idx"}, o_data, exp_idx);
    check({tag, "_intr"}, intr, 1);
    $display("scan %s: idx %0d expected %0d latency %0d", tag, o_data, exp_idx, lat);
  endtask

  int a[N];
  logic [VW-1:0] v1, v2, v3;
  int seen;

  initial begin
    rst_n = 1'b0; i_data = '0; i_valid = 1'b0; i_intr_clear = 1'b0;
    #3;
    check("rst_busy", o_busy, 0);
    check("rst_data", o_data, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_intr", intr, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Ties resolve to the lower index (7 at indices 2 and 6); reset release and
    // the first i_valid share an edge.
    a = '{3, -1, 7, 2, 0, 5, 7, 1, -4, 6};
    v1 = pack(a);
    run_scan("tie", v1, 0, '0);
    check("tie_idx2", o_data, 2);
    @(negedge clk);
    check("pulse_width", o_data_valid, 0);
    check("busy_after", o_busy, 0);
    check("hold_data", o_data, 2);
    check("intr_sticky", intr, 1);

    i_intr_clear = 1'b1;
    @(negedge clk);
    i_intr_clear = 1'b0;
    check("intr_clear", intr, 0);

    a = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, -1};
    a[8] = -2;
    v1 = pack(a);
    run_scan("allneg", v1, 0, '0);
    check("allneg_idx9", o_data, 9);

    a = '{-5, -1, 1, -5, -5, -5, -5, -5, -5, -5};
    v1 = pack(a);
    run_scan("mixsign", v1, 0, '0);
    check("mixsign_idx2", o_data, 2);

    // Stray i_valid mid-scan is ignored; i_valid in the result cycle starts
    // the next scan.
    a = '{0, 0, 0, 0, 100, 0, 0, 0, 0, 0};
    v1 = pack(a);
    a = '{0, 0, 0, 0, 0, 0, 0, 0, 500, 0};
    v2 = pack(a);
    run_scan("ignore", v1, 4, v2);
    check("ignore_idx4", o_data, 4);
    a = '{1, 2, 3, 4, 5, 6, 90, 8, 9, 10};
    v3 = pack(a);
    run_scan("b2b", v3, 0, '0);
    check("b2b_idx6", o_data, 6);

    // Clear held across completion: set wins in the completion cycle.
    @(negedge clk);
    i_intr_clear = 1'b1;
    @(negedge clk);
    check("clr_held_pre", intr, 0);
    a = '{5, 4, 3, 2, 1, 0, -1, -2, -3, -4};
    run_scan("clrheld", pack(a), 0, '0);
    @(negedge clk);
    check("clr_held_post", intr, 0);
    i_intr_clear = 1'b0;

    // Reset mid-scan.
    a = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, -11};
    run_scan("prerst", pack(a), 0, '0);
    a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    i_data = pack(a);
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_data", o_data, 0);
    check("arst_valid", o_data_valid, 0);
    check("arst_intr", intr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_data_valid || intr) seen++;
    end
    check("arst_no_result", seen, 0);
    a = '{1, 2, 3, 4, 5, 60, 7, 8, 9, 10};
    run_scan("postrst", pack(a), 0, '0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a = '{1, 2, 3, 44, 5, 6, 7, 8, 9, 10};
    run_scan("firstedge", pack(a), 0, '0);

    // Ten back-to-back random vectors, some with ties at the maximum.
    for (int t = 0; t < 10; t++) begin
      int p, q;
      for (int k = 0; k < N; k++) a[k] = int'($urandom_range(4000)) - 2000;
      p = int'($urandom_range(N - 1));
      a[p] = 3000 + int'($urandom_range(500));
      if ($urandom_range(2) == 0) begin
        q = int'($urandom_range(N - 1));
        a[q] = a[p];
      end
      run_scan($sformatf("rand%0d", t), pack(a), 0, '0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
